// File: rtl/multicycle_chunk_adder.sv
// Chunked add/subtract: CHUNK_WIDTH bits per clock with a registered carry between chunks.
// Start/done handshake; results hold until the next accepted start.
module multicycle_chunk_adder #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CHUNK_WIDTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic                  START_In,
  input  logic                  SUB_In,
  input  logic [DATA_WIDTH-1:0] A_In,
  input  logic [DATA_WIDTH-1:0] B_In,
  input  logic                  Cin_In,
  output logic                  BUSY_Out,
  output logic                  DONE_Out,
  output logic [DATA_WIDTH-1:0] Q_Out,
  output logic                  Cout_Out,
  output logic                  OVF_Out
);

  localparam int unsigned NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  a_q;
  logic [DATA_WIDTH-1:0]  b_q;
  logic                   carry_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [31:0]            base;
  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   sum;

  always_comb begin
    base    = 32'(cnt_q) * CHUNK_WIDTH;
    a_chunk = a_q[base +: CHUNK_WIDTH];
    b_chunk = b_q[base +: CHUNK_WIDTH];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      BUSY_Out <= 1'b0;
      DONE_Out <= 1'b0;
      Q_Out    <= '0;
      Cout_Out <= 1'b0;
      OVF_Out  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          DONE_Out <= 1'b0;
          if (START_In) begin
            a_q      <= A_In;
            // Subtraction is A + ~B + 1, so the forced carry-in replaces Cin.
            b_q      <= SUB_In ? ~B_In : B_In;
            carry_q  <= SUB_In | Cin_In;
            cnt_q    <= '0;
            BUSY_Out <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          Q_Out[base +: CHUNK_WIDTH] <= sum[CHUNK_WIDTH-1:0];
          carry_q <= sum[CHUNK_WIDTH];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q  <= StDone;
            BUSY_Out <= 1'b0;
            DONE_Out <= 1'b1;
            Cout_Out <= sum[CHUNK_WIDTH];
            // The top chunk's sum MSB is the result sign bit.
            OVF_Out  <= (a_q[MSB] == b_q[MSB]) && (sum[CHUNK_WIDTH-1] != a_q[MSB]);
          end
        end
        StDone: begin
          DONE_Out <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Directed bench for multicycle_chunk_adder at CHUNK_WIDTH 4 (main), 1 and 16 (sweep).
module tb_multicycle_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;

  logic        busy4, done4, cout4, ovf4;
  logic [15:0] q4;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] q1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] q16;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  multicycle_chunk_adder #(.DATA_WIDTH(16), .CHUNK_WIDTH(4)) u_dut4 (
    .CLOCK_50(clk), .RESET_InHigh(rst), .START_In(start), .SUB_In(sub), .A_In(a), .B_In(b),
    .Cin_In(cin), .BUSY_Out(busy4), .DONE_Out(done4), .Q_Out(q4), .Cout_Out(cout4),
    .OVF_Out(ovf4)
  );

  multicycle_chunk_adder #(.DATA_WIDTH(16), .CHUNK_WIDTH(1)) u_dut1 (
    .CLOCK_50(clk), .RESET_InHigh(rst), .START_In(start), .SUB_In(sub), .A_In(a), .B_In(b),
    .Cin_In(cin), .BUSY_Out(busy1), .DONE_Out(done1), .Q_Out(q1), .Cout_Out(cout1),
    .OVF_Out(ovf1)
  );

  multicycle_chunk_adder #(.DATA_WIDTH(16), .CHUNK_WIDTH(16)) u_dut16 (
    .CLOCK_50(clk), .RESET_InHigh(rst), .START_In(start), .SUB_In(sub), .A_In(a), .B_In(b),
    .Cin_In(cin), .BUSY_Out(busy16), .DONE_Out(done16), .Q_Out(q16), .Cout_Out(cout16),
    .OVF_Out(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, q} from plain unsigned/signed arithmetic.
  function automatic logic [17:0] model(input logic s, input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv);
    logic [16:0] f;
    logic        c;
    logic        o;
    if (s) begin
      f = {1'b0, av - bv};
      c = (av >= bv);
      o = (av[15] != bv[15]) && (f[15] != av[15]);
    end else begin
      f = {1'b0, av} + {1'b0, bv} + {16'b0, cv};
      c = f[16];
      o = (av[15] == bv[15]) && (f[15] != av[15]);
    end
    return {o, c, f[15:0]};
  endfunction

  task automatic do_op(input string tag, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic cv, input logic [15:0] eq,
                       input logic ec, input logic eo, input bit inject);
    int lat4 = 0, lat1 = 0, lat16 = 0, n4 = 0, n1 = 0, n16 = 0;
    logic [15:0] qd4 = '0;
    sub = s; a = av; b = bv; cin = cv; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 1) begin
        check({tag, ".busy4"}, 32'(busy4), 32'd1);
        check({tag, ".busy1"}, 32'(busy1), 32'd1);
        check({tag, ".busy16"}, 32'(busy16), 32'd1);
      end
      // Competing request while busy (dut16 is in DONE at that edge).
      if (inject && i == 2) begin
        a = 16'hAAAA; b = 16'h5555; sub = ~s; cin = ~cv; start = 1'b1;
      end
      if (done4) begin n4++; if (lat4 == 0) begin lat4 = i; qd4 = q4; end end
      if (done1) begin n1++; if (lat1 == 0) lat1 = i; end
      if (done16) begin n16++; if (lat16 == 0) lat16 = i; end
    end
    check({tag, ".lat4"}, 32'(lat4), 32'd5);
    check({tag, ".lat1"}, 32'(lat1), 32'd17);
    check({tag, ".lat16"}, 32'(lat16), 32'd2);
    check({tag, ".ndone4"}, 32'(n4), 32'd1);
    check({tag, ".ndone1"}, 32'(n1), 32'd1);
    check({tag, ".ndone16"}, 32'(n16), 32'd1);
    check({tag, ".q4_at_done"}, 32'(qd4), 32'(eq));
    check({tag, ".q4"}, 32'(q4), 32'(eq));
    check({tag, ".cout4"}, 32'(cout4), 32'(ec));
    check({tag, ".ovf4"}, 32'(ovf4), 32'(eo));
    check({tag, ".q1"}, 32'(q1), 32'(eq));
    check({tag, ".cout1"}, 32'(cout1), 32'(ec));
    check({tag, ".ovf1"}, 32'(ovf1), 32'(eo));
    check({tag, ".q16"}, 32'(q16), 32'(eq));
    check({tag, ".cout16"}, 32'(cout16), 32'(ec));
    check({tag, ".ovf16"}, 32'(ovf16), 32'(eo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_q [3];
    logic        exp_c [3];
    logic        exp_o [3];
    int          exp_i [3];
    int          k;
    int          nd;
    logic [17:0] m;
    logic        rs;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy4", 32'(busy4), 32'd0);
    check("reset.done4", 32'(done4), 32'd0);
    check("reset.q4", 32'(q4), 32'd0);
    check("reset.cout4", 32'(cout4), 32'd0);
    check("reset.ovf4", 32'(ovf4), 32'd0);
    check("reset.q1", 32'(q1), 32'd0);
    check("reset.q16", 32'(q16), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("add_cin", 1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);
    do_op("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("sub_borrow", 1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op("busy_start", 1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b1);

    // Reset two cycles into RUN: outputs clear and no DONE follows.
    sub = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.busy4", 32'(busy4), 32'd0);
    check("midrst.done4", 32'(done4), 32'd0);
    check("midrst.q4", 32'(q4), 32'd0);
    check("midrst.cout4", 32'(cout4), 32'd0);
    check("midrst.ovf4", 32'(ovf4), 32'd0);
    check("midrst.busy1", 32'(busy1), 32'd0);
    check("midrst.done16", 32'(done16), 32'd0);
    check("midrst.q16", 32'(q16), 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done4 || done1 || done16) nd++;
    end
    check("midrst.no_done", 32'(nd), 32'd0);
    check("midrst.idle_busy4", 32'(busy4), 32'd0);

    // START held high: three operations back to back on the CHUNK_WIDTH=4 instance.
    exp_q[0] = 16'h2345; exp_c[0] = 1'b0; exp_o[0] = 1'b0; exp_i[0] = 5;
    exp_q[1] = 16'h0000; exp_c[1] = 1'b1; exp_o[1] = 1'b0; exp_i[1] = 11;
    exp_q[2] = 16'h8000; exp_c[2] = 1'b0; exp_o[2] = 1'b1; exp_i[2] = 17;
    k = 0;
    sub = 1'b0; cin = 1'b0; a = 16'h1234; b = 16'h1111; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin a = 16'hFFFF; b = 16'h0001; end
      if (i == 7) begin a = 16'h7FFF; b = 16'h0001; end
      if (i == 13) start = 1'b0;
      if (done4) begin
        if (k < 3) begin
          check($sformatf("b2b%0d.cycle", k), 32'(i), 32'(exp_i[k]));
          check($sformatf("b2b%0d.q", k), 32'(q4), 32'(exp_q[k]));
          check($sformatf("b2b%0d.cout", k), 32'(cout4), 32'(exp_c[k]));
          check($sformatf("b2b%0d.ovf", k), 32'(ovf4), 32'(exp_o[k]));
        end
        k++;
      end
    end
    check("b2b.ndone", 32'(k), 32'd3);
    repeat (4) @(posedge clk);
    #1;

    // Random operands across all three chunk widths.
    for (int t = 0; t < 6; t++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      m  = model(rs, ra, rb, rc);
      do_op($sformatf("rand%0d", t), rs, ra, rb, rc, m[15:0], m[16], m[17], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_chunk_adder.md
Name: multicycle_chunk_adder

Overview:
- Parametrised successor to the one-bit full adder cell.
- Adds or subtracts two DATA_WIDTH-bit operands plus carry-in, CHUNK_WIDTH bits per clock, with a registered carry chain between chunks.
- Trades latency for a short carry path, so wide arithmetic meets timing at the board clock.
- Sits between operand registers and result consumers, using a start/done handshake.

Parameters:
- DATA_WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4, bits added per clock cycle; 1 gives a fully bit-serial adder.
- NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived localparam; not overridable.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- RESET_InHigh  in  1  synchronous, active-high reset.
- START_In  in  1  request; sampled only in IDLE.
- SUB_In  in  1  mode, captured at start: 0 = A+B+Cin, 1 = A-B (Cin ignored).
- A_In  in  DATA_WIDTH  operand A, captured at start.
- B_In  in  DATA_WIDTH  operand B, captured at start.
- Cin_In  in  1  carry-in, captured at start.
- BUSY_Out  out  1  high while in RUN.
- DONE_Out  out  1  one-cycle pulse when result is valid.
- Q_Out  out  DATA_WIDTH  sum/difference; held until the next accepted start.
- Cout_Out  out  1  final carry out; for SUB, 1 means no borrow (A >= B unsigned).
- OVF_Out  out  1  signed two's-complement overflow of the operation.

Behaviour:
- Reset, synchronous and active-high: state=IDLE; BUSY_Out=0, DONE_Out=0, Q_Out=0, Cout_Out=0, OVF_Out=0; chunk counter=0; carry reg=0.
- Reset has priority over every other input in the same cycle.
- Reset asserted mid-RUN aborts the operation; no DONE pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE with START_In=1:
  - capture A_In.
  - capture B_In, inverted if SUB_In=1.
  - carry reg = SUB_In ? 1 : Cin_In.
  - counter=0; go to RUN; BUSY_Out=1 from the next cycle.
- RUN, each cycle:
  - chunk k = counter, bits [k*CW +: CW].
  - {c, s} = A_k + B'_k + carry, computed at CHUNK_WIDTH+1 bits.
  - write s into the Q shift/position; carry reg = c; counter++.
  - when counter = NUM_CHUNKS-1 the last chunk completes and the state goes to DONE.
- DONE, one cycle:
  - DONE_Out=1, BUSY_Out=0.
  - Cout_Out = final carry.
  - OVF_Out = (A[msb] == B'[msb]) && (Q[msb] != A[msb]).
  - next state IDLE.
- Latency: a start sampled at edge t gives DONE_Out high during the cycle after edge t+NUM_CHUNKS.
- Throughput: one operation per NUM_CHUNKS+2 cycles.
- START_In in RUN or DONE is ignored; it is not queued, and operands and mode changes are ignored.
- START_In held high continuously: a new operation is accepted in each IDLE cycle.
- Q_Out bits of chunks not yet computed in RUN are don't-care. The bench checks Q_Out only on DONE_Out and while idle afterwards.
- Q_Out/Cout_Out/OVF_Out stay stable from DONE until the next accepted start.
- Wrap-around: the carry out of the top chunk goes only to Cout_Out; Q_Out is modulo 2^DATA_WIDTH.
- CHUNK_WIDTH = DATA_WIDTH is legal: single RUN cycle, latency 2.

Test Plan:
- Reset mid-RUN: DATA_WIDTH=16, CHUNK_WIDTH=4, A=0x1234, B=0x1111, Cin=0, start, assert reset after 2 cycles -> no DONE; all outputs 0; IDLE next cycle.
- Add with carry-in: A=0x1234, B=0x1111, Cin=1, SUB=0 -> DONE 5 cycles after start edge; Q=0x2346, Cout=0, OVF=0.
- Ripple across all chunks: A=0xFFFF, B=0x0001, Cin=0 -> Q=0x0000, Cout=1, OVF=0.
- Signed overflow on add: A=0x7FFF, B=0x0001 -> Q=0x8000, Cout=0, OVF=1.
- Subtract with borrow: SUB=1, A=0x0003, B=0x0005, Cin=1 -> Q=0xFFFE, Cout=0, OVF=0.
- Subtract overflow: SUB=1, A=0x8000, B=0x0001 -> Q=0x7FFF, Cout=1, OVF=1.
- Start ignored while busy: pulse START_In with new operands during RUN -> first result unchanged; exactly one DONE pulse.
- Back-to-back: START_In held high for 3 operations -> DONE pulses spaced 6 cycles apart with correct results.
- Parameter sweep with random operands: CHUNK_WIDTH in {1, 4, 16} -> results match A+B+Cin; latencies 17, 5, 2.
